fft_result_tx: RTL and testbench

Serial result transmitter for the FFT core: once a transform completes it reads the 128 complex results out of the result buffer and shifts them to the external master over the same slave-select / serial-clock link used to load samples. It is the slave-side transmit counterpart of the sample receiver. The master drives `ss` and `clk_in`; this block drives `data_out`, one bit per `clk_in` period, LSB first.

---
 rtl/fft_spi_pkg.sv | 34 +++
 rtl/fft_result_tx_if.sv | 31 +++
 rtl/sync_edge_det.sv | 52 +++++
 rtl/fft_result_tx.sv | 149 ++++++++++++++
 tb/tb_fft_result_tx.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_spi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_spi_pkg : shared constants, state codes and result word layout for    |
// |               the FFT serial link blocks.                                  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package fft_spi_pkg;

  localparam int NPOINTS = 128;
  localparam int WORD_W  = 16;
  localparam int SHIFT_W = 2 * WORD_W;
  localparam int PT_W    = $clog2(NPOINTS);
  localparam int BIT_W   = $clog2(SHIFT_W);

  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(SHIFT_W - 1);
  localparam logic [PT_W-1:0]  LAST_POINT = PT_W'(NPOINTS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_SHIFT = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  typedef logic [2:0] state_t;

  // Bit 0 of the packed word is the first bit on the wire (real LSB).
  typedef struct packed {
    logic [WORD_W-1:0] imag;
    logic [WORD_W-1:0] re;
  } result_t;

endpackage
`default_nettype wire

// File: rtl/fft_result_tx_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_result_tx_if : serial link and result-buffer read port bundle.        |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
interface fft_result_tx_if;
  import fft_spi_pkg::*;

  logic              ss;
  logic              clk_in;
  logic              start;
  logic [WORD_W-1:0] rd_real;
  logic [WORD_W-1:0] rd_complex;
  logic              rd_en;
  logic [PT_W-1:0]   rd_addr;
  logic              data_out;
  logic              busy;
  logic              frame_done;

  modport master (
    output ss, clk_in, start, rd_real, rd_complex,
    input  rd_en, rd_addr, data_out, busy, frame_done
  );

  modport slave (
    input  ss, clk_in, start, rd_real, rd_complex,
    output rd_en, rd_addr, data_out, busy, frame_done
  );

endinterface
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sync_edge_det : multi-flop synchronizer (reset high) with falling-edge    |
// |                 pulse on the synchronized value.                           |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module sync_edge_det #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic n_rst,
  input  wire logic d_i,
  output logic      sync_o,
  output logic      fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  generate
    if (STAGES == 1) begin : g_single
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          sync_q <= '1;
        end else begin
          sync_q <= d_i;
        end
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          sync_q <= '1;
        end else begin
          sync_q <= {sync_q[STAGES-2:0], d_i};
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign fall_o = prev_q & ~sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/fft_result_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_result_tx : streams 128 complex FFT results LSB-first to the master   |
// |                 on the ss / clk_in link, one bit per clk_in fall.          |
// | Revision      : 1.0                                                        |
// +----------------------------------------------------------------------------+
module fft_result_tx
  import fft_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  wire logic         clk,
  input  wire logic         n_rst,
  fft_result_tx_if.slave    bus
);

  logic w_ss_sync;
  logic w_ss_fall_unused;
  logic w_sck_sync_unused;
  logic w_sck_fall;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk    (clk),
    .n_rst  (n_rst),
    .d_i    (bus.ss),
    .sync_o (w_ss_sync),
    .fall_o (w_ss_fall_unused)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk    (clk),
    .n_rst  (n_rst),
    .d_i    (bus.clk_in),
    .sync_o (w_sck_sync_unused),
    .fall_o (w_sck_fall)
  );

  state_t           state_q, state_d;
  logic [PT_W-1:0]  point_q, point_d;
  logic [BIT_W-1:0] bit_q,   bit_d;
  result_t          shift_q, shift_d;
  logic             data_q,  data_d;

  always_comb begin
    state_d = state_q;
    point_d = point_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;

    case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        if (bus.start) begin
          state_d = ST_ARMED;
        end
      end

      ST_ARMED: begin
        point_d = '0;
        data_d  = 1'b0;
        if (!w_ss_sync) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (w_ss_sync) begin
          state_d = ST_ARMED;
          point_d = '0;
          data_d  = 1'b0;
        end else begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        if (w_ss_sync) begin
          state_d = ST_ARMED;
          point_d = '0;
          data_d  = 1'b0;
        end else begin
          shift_d = {bus.rd_complex, bus.rd_real};
          bit_d   = '0;
          data_d  = bus.rd_real[0];
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (w_ss_sync) begin
          state_d = ST_ARMED;
          point_d = '0;
          data_d  = 1'b0;
        end else if (w_sck_fall) begin
          if (bit_q != LAST_BIT) begin
            shift_d = result_t'({1'b0, shift_q[SHIFT_W-1:1]});
            bit_d   = bit_q + 1'b1;
            data_d  = shift_q[1];
          end else begin
            // Line returns low between words and after the final bit.
            data_d = 1'b0;
            if (point_q != LAST_POINT) begin
              point_d = point_q + 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        data_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        data_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      point_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      point_q <= point_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
    end
  end

  assign bus.rd_en      = (state_q == ST_FETCH);
  assign bus.rd_addr    = point_q;
  assign bus.data_out   = data_q;
  assign bus.busy       = (state_q == ST_ARMED) || (state_q == ST_FETCH) ||
                          (state_q == ST_LOAD)  || (state_q == ST_SHIFT);
  assign bus.frame_done = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fft_result_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_result_tx : serial-master bench with result-buffer model.          |
// | Revision         : 1.0                                                     |
// +----------------------------------------------------------------------------+
module tb_fft_result_tx;
  import fft_spi_pkg::*;

  localparam int SYNC       = 2;
  localparam int FRAME_BITS = NPOINTS * SHIFT_W;
  localparam int CLK_NS     = 10;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  fft_result_tx_if bus ();

  fft_result_tx #(.SYNC_STAGES(SYNC)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus.slave)
  );

  logic [WORD_W-1:0] mem_re [NPOINTS];
  logic [WORD_W-1:0] mem_im [NPOINTS];

  // Result buffer: registered read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_real    <= mem_re[bus.rd_addr];
      bus.rd_complex <= mem_im[bus.rd_addr];
    end
  end

  int checks   = 0;
  int failures = 0;

  int                rd_count;
  int                rd_multi;
  int                fd_count;
  time               fd_time;
  time               last_fall;
  logic [PT_W-1:0]   addr_q [$];
  logic              prev_rd = 1'b0;
  logic              rx [FRAME_BITS];

  always @(negedge clk) begin
    if (bus.rd_en) begin
      if (prev_rd) rd_multi++;
      rd_count++;
      addr_q.push_back(bus.rd_addr);
    end
    prev_rd = bus.rd_en;
    if (bus.frame_done) begin
      fd_count++;
      fd_time = $time;
    end
  end

  typedef struct {
    string name;
    int    lo;
    int    hi;
    logic  val;
  } range_vec_t;

  range_vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    rd_count = 0;
    rd_multi = 0;
    fd_count = 0;
    addr_q.delete();
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // One clk_in period: sample (master's view of the last rising edge), fall, low 4, rise, high 4.
  task automatic clk_period(input bit glitch, output logic b);
    b = bus.data_out;
    bus.clk_in = 1'b0;
    last_fall  = $time;
    repeat (4) @(negedge clk);
    bus.clk_in = 1'b1;
    if (glitch) begin
      pulse_start();
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic run_bits(input int n, input int glitch_at);
    logic b;
    for (int i = 0; i < n; i++) begin
      clk_period(i == glitch_at, b);
      rx[i] = b;
    end
  endtask

  function automatic logic [31:0] rx_word(input int k);
    logic [31:0] w;
    for (int b = 0; b < SHIFT_W; b++) w[b] = rx[k*SHIFT_W + b];
    return w;
  endfunction

  initial begin
    int bad;
    int rd_before;
    int glitch;

    n_rst      = 1'b0;
    bus.ss     = 1'b1;
    bus.clk_in = 1'b1;
    bus.start  = 1'b0;
    repeat (3) @(negedge clk);

    check("reset_data_out",   32'(bus.data_out),   32'd0);
    check("reset_rd_en",      32'(bus.rd_en),      32'd0);
    check("reset_rd_addr",    32'(bus.rd_addr),    32'd0);
    check("reset_busy",       32'(bus.busy),       32'd0);
    check("reset_frame_done", 32'(bus.frame_done), 32'd0);

    n_rst = 1'b1;
    @(negedge clk);

    // ---- Full frame: real[k]=k, imag[k]=0x8000|k, with a stray start mid-frame
    for (int k = 0; k < NPOINTS; k++) begin
      mem_re[k] = WORD_W'(k);
      mem_im[k] = 16'h8000 | WORD_W'(k);
    end
    clear_mon();
    pulse_start();
    repeat (4) @(negedge clk);
    check("armed_busy",     32'(bus.busy),  32'd1);
    check("armed_no_rd_en", 32'(rd_count),  32'd0);
    bus.ss = 1'b0;
    repeat (6) @(negedge clk);
    glitch = int'($urandom_range(40, FRAME_BITS - 40));
    run_bits(FRAME_BITS, glitch);
    repeat (4) @(negedge clk);
    check("frameA_done_count", 32'(fd_count), 32'd1);
    check("frameA_done_latency", 32'(fd_time - last_fall), 32'((SYNC + 1) * CLK_NS));
    check("frameA_busy_after", 32'(bus.busy), 32'd0);
    check("frameA_data_idle",  32'(bus.data_out), 32'd0);
    check("frameA_rd_count",   32'(rd_count), 32'(NPOINTS));
    check("frameA_rd_multi",   32'(rd_multi), 32'd0);
    bad = 0;
    foreach (addr_q[i]) if (int'(addr_q[i]) != i) bad++;
    check("frameA_rd_order", 32'(bad), 32'd0);
    bad = 0;
    for (int k = 0; k < NPOINTS; k++) begin
      if (rx_word(k) !== {mem_im[k], mem_re[k]}) begin
        bad++;
        if (bad <= 4)
          check($sformatf("frameA_word%0d", k), rx_word(k), {mem_im[k], mem_re[k]});
      end
    end
    check("frameA_bad_words", 32'(bad), 32'd0);
    bus.ss = 1'b1;
    repeat (6) @(negedge clk);

    // ---- Single-word pattern frame checked against bit-range table
    vecs[0] = '{name: "patt_bits0_6",    lo: 0,  hi: 6,              val: 1'b0};
    vecs[1] = '{name: "patt_bits7_14",   lo: 7,  hi: 14,             val: 1'b1};
    vecs[2] = '{name: "patt_bit15",      lo: 15, hi: 15,             val: 1'b0};
    vecs[3] = '{name: "patt_bits16_end", lo: 16, hi: FRAME_BITS - 1, val: 1'b0};
    for (int k = 0; k < NPOINTS; k++) begin
      mem_re[k] = '0;
      mem_im[k] = '0;
    end
    mem_re[0] = 16'h7F80;
    clear_mon();
    pulse_start();
    bus.ss = 1'b0;
    repeat (6) @(negedge clk);
    run_bits(FRAME_BITS, -1);
    repeat (4) @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      bad = 0;
      for (int i = vecs[v].lo; i <= vecs[v].hi; i++) if (rx[i] !== vecs[v].val) bad++;
      check(vecs[v].name, 32'(bad), 32'd0);
    end
    check("patt_done_count", 32'(fd_count), 32'd1);
    bus.ss = 1'b1;
    repeat (6) @(negedge clk);

    // ---- Abort after 100 bits, then restart from result 0
    for (int k = 0; k < NPOINTS; k++) begin
      mem_re[k] = WORD_W'($urandom);
      mem_im[k] = WORD_W'($urandom);
    end
    mem_re[3] = 16'hFFFF;
    pulse_start();
    bus.ss = 1'b0;
    repeat (6) @(negedge clk);
    run_bits(100, -1);
    check("abort_pre_data", 32'(bus.data_out), 32'd1);
    bus.ss = 1'b1;
    repeat (SYNC) @(negedge clk);
    check("abort_data_held", 32'(bus.data_out), 32'd1);
    @(negedge clk);
    check("abort_data_low", 32'(bus.data_out), 32'd0);
    repeat (4) @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd1);
    bus.ss = 1'b0;
    repeat (6) @(negedge clk);
    run_bits(2 * SHIFT_W, -1);
    check("restart_word0", rx_word(0), {mem_im[0], mem_re[0]});
    check("restart_word1", rx_word(1), {mem_im[1], mem_re[1]});

    // ---- Asynchronous reset in the middle of a word
    #2;
    n_rst = 1'b0;
    #1;
    check("midrst_data_out",   32'(bus.data_out),   32'd0);
    check("midrst_rd_en",      32'(bus.rd_en),      32'd0);
    check("midrst_rd_addr",    32'(bus.rd_addr),    32'd0);
    check("midrst_busy",       32'(bus.busy),       32'd0);
    check("midrst_frame_done", 32'(bus.frame_done), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    bus.ss = 1'b1;
    repeat (5) @(negedge clk);
    rd_before = rd_count;
    bus.ss = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_rd_en", 32'(rd_count - rd_before), 32'd0);
    check("midrst_idle_busy", 32'(bus.busy), 32'd0);

    // ---- start while ss already low: rd_en two cycles after start
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ss_low_start_rd_en_c1", 32'(bus.rd_en), 32'd0);
    @(negedge clk);
    check("ss_low_start_rd_en_c2", 32'(bus.rd_en), 32'd1);
    check("ss_low_start_rd_addr", 32'(bus.rd_addr), 32'd0);
    @(negedge clk);
    check("ss_low_start_rd_en_c3", 32'(bus.rd_en), 32'd0);
    bus.ss = 1'b1;
    repeat (6) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
